adder55_share_arbiter: RTL and testbench

- Shares one instance of the team's 55-bit + 39-bit zero-extending adder (customAdder55_16, 56-bit Sum) between NUM_REQ requesters.
- Requesters issue add transactions over valid/ready handshakes.
- Round-robin arbitration selects one requester, registers its operands, runs the adder for one cycle and returns a registered 56-bit result tagged with the requester ID.
- Sits between the partial-product accumulation clients and the shared wide adder.

---
 rtl/adder55_share_pkg.sv | 15 +
 rtl/adder55_share_arbiter_rr.sv | 32 +++
 rtl/customAdder55_16.sv | 10 +
 rtl/adder55_share_arbiter.sv | 118 +++++++++++
 tb/tb_adder55_share_arbiter.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder55_share_pkg.sv
// rtl/adder55_share_pkg.sv - shared widths, state encoding and defaults for the adder share arbiter
package adder55_share_pkg;

    localparam int OPA_W           = 55;
    localparam int OPB_W           = 39;
    localparam int SUM_W           = 56;
    localparam int DEFAULT_NUM_REQ = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/adder55_share_arbiter_rr.sv
// rtl/adder55_share_arbiter_rr.sv - combinational round-robin picker starting after the last grant
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx
);

    int idx;

    // Walk from the lowest priority upward so the last hit is the closest to ptr+1.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        idx     = 0;
        if (en) begin
            for (int off = NUM_REQ; off >= 1; off--) begin
                idx = (int'(ptr) + off) % NUM_REQ;
                if (req[idx]) begin
                    gnt      = '0;
                    gnt[idx] = 1'b1;
                    gnt_idx  = ID_W'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/customAdder55_16.sv
// rtl/customAdder55_16.sv - 55-bit plus zero-extended 39-bit adder with full 56-bit sum
module customAdder55_16 (
    input  logic [54:0] A,
    input  logic [38:0] B,
    output logic [55:0] Sum
);

    assign Sum = {1'b0, A} + {17'b0, B};

endmodule

// File: rtl/adder55_share_arbiter.sv
// rtl/adder55_share_arbiter.sv - round-robin share of one wide adder among NUM_REQ requesters
module adder55_share_arbiter
    import adder55_share_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*OPA_W-1:0] req_a,
    input  logic [NUM_REQ*OPB_W-1:0] req_b,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [SUM_W-1:0]         res_sum,
    output logic [ID_W-1:0]          res_id,
    output logic                     busy
);

    localparam logic [ID_W-1:0] PTR_RESET = ID_W'(NUM_REQ - 1);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    opid_q, opid_d;
    logic [OPA_W-1:0]   opa_q, opa_d;
    logic [OPB_W-1:0]   opb_q, opb_d;
    logic [SUM_W-1:0]   res_sum_q, res_sum_d;
    logic [ID_W-1:0]    res_id_q, res_id_d;

    logic               arb_en;
    logic               granted;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic [SUM_W-1:0]   add_sum;

    // A new grant is possible when idle or when the held result is being consumed.
    assign arb_en  = (state_q == IDLE) || ((state_q == RESP) && res_ready);
    assign granted = |gnt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req     (req_valid),
        .ptr     (ptr_q),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    customAdder55_16 u_add (
        .A   (opa_q),
        .B   (opb_q),
        .Sum (add_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= PTR_RESET;
            opid_q    <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            res_sum_q <= '0;
            res_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            opid_q    <= opid_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            res_sum_q <= res_sum_d;
            res_id_q  <= res_id_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        opid_d    = opid_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        res_sum_d = res_sum_q;
        res_id_d  = res_id_q;

        if (granted) begin
            ptr_d  = gnt_idx;
            opid_d = gnt_idx;
            opa_d  = req_a[int'(gnt_idx)*OPA_W +: OPA_W];
            opb_d  = req_b[int'(gnt_idx)*OPB_W +: OPB_W];
        end

        case (state_q)
            IDLE: begin
                if (granted) state_d = EXEC;
            end
            EXEC: begin
                res_sum_d = add_sum;
                res_id_d  = opid_q;
                state_d   = RESP;
            end
            RESP: begin
                if (res_ready) state_d = granted ? EXEC : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = gnt;
        res_valid = (state_q == RESP);
        busy      = (state_q != IDLE);
        res_sum   = res_sum_q;
        res_id    = res_id_q;
    end

endmodule

// File: tb/tb_adder55_share_arbiter.sv
// tb/tb_adder55_share_arbiter.sv - directed self-checking bench for adder55_share_arbiter
module tb_adder55_share_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*55-1:0]   req_a;
    logic [N*39-1:0]   req_b;
    logic              res_valid;
    logic              res_ready;
    logic [55:0]       res_sum;
    logic [IDW-1:0]    res_id;
    logic              busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit started = 1'b0;

    int grants[$];
    int hs_cyc[$];

    int          m_phase;
    int          m_last;
    int          m_id;
    longint      m_a, m_b;
    longint      m_res_sum;
    int          m_res_id;

    adder55_share_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_id    (res_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic int model_pick();
        bit en;
        en = (m_phase == 0) || (m_phase == 2 && res_ready);
        return en ? rr_pick(req_valid, m_last) : -1;
    endfunction

    // Transaction-level reference: who may be granted, what sum each grant produces.
    always @(posedge clk) begin : model
        int p;
        if (rst) begin
            m_phase   <= 0;
            m_last    <= N - 1;
            m_res_sum <= 0;
            m_res_id  <= 0;
        end else begin
            p = model_pick();
            if (p >= 0) begin
                m_last  <= p;
                m_id    <= p;
                m_a     <= longint'(req_a[p*55 +: 55]);
                m_b     <= longint'(req_b[p*39 +: 39]);
                m_phase <= 1;
            end else if (m_phase == 1) begin
                m_res_sum <= m_a + m_b;
                m_res_id  <= m_id;
                m_phase   <= 2;
            end else if (m_phase == 2 && res_ready) begin
                m_phase <= 0;
            end
        end
    end

    always @(negedge clk) begin : compare
        int p;
        logic [N-1:0] exp_rdy;
        if (!rst && started) begin
            p = model_pick();
            exp_rdy = '0;
            if (p >= 0) exp_rdy[p] = 1'b1;
            check("req_ready", 64'(req_ready), 64'(exp_rdy));
            check("res_valid", 64'(res_valid), 64'(m_phase == 2));
            check("busy", 64'(busy), 64'(m_phase != 0));
            if (m_phase == 2) begin
                check("res_sum", 64'(res_sum), m_res_sum);
                check("res_id", 64'(res_id), 64'(m_res_id));
            end
            for (int i = 0; i < N; i++) if (req_ready[i]) grants.push_back(i);
            if (res_valid && res_ready) hs_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [54:0] a, input logic [38:0] b);
        req_a[i*55 +: 55] = a;
        req_b[i*39 +: 39] = b;
        req_valid[i]      = 1'b1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        res_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_result();
        for (int k = 0; k < 10 && !res_valid; k++) step();
        check("res_timeout", 64'(res_valid), 64'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int exp_order[6];
        exp_order = '{0, 1, 2, 3, 0, 1};
        req_a = '0;
        req_b = '0;
        do_reset();
        started = 1'b1;

        #1;
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_sum", 64'(res_sum), 64'd0);
        check("rst_res_id", 64'(res_id), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);

        // Single request: carry out of the 55-bit operand.
        set_req(0, 55'h7F_FFFF_FFFF_FFFF, 39'h1);
        #1;
        check("t1_ready", 64'(req_ready), 64'b0001);
        step();
        req_valid = '0;
        check("t1_exec_valid", 64'(res_valid), 64'd0);
        step();
        check("t1_valid_t2", 64'(res_valid), 64'd1);
        check("t1_sum", 64'(res_sum), 64'h0080_0000_0000_0000);
        check("t1_id", 64'(res_id), 64'd0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // Max-carry on requester 1.
        set_req(1, '1, '1);
        step();
        req_valid = '0;
        wait_result();
        check("t2_sum", 64'(res_sum), 64'h0080_007F_FFFF_FFFE);
        check("t2_id", 64'(res_id), 64'd1);
        res_ready = 1'b1;
        step();

        // Fairness with all requesters continuously valid.
        do_reset();
        grants.delete();
        hs_cyc.delete();
        res_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 55'(i * 1000 + 7), 39'(i * 3 + 1));
        repeat (12) step();
        req_valid = '0;
        repeat (3) step();
        check("fair_count", 64'(grants.size() >= 6), 64'd1);
        for (int k = 0; k < 6 && k < grants.size(); k++)
            check("fair_order", 64'(grants[k]), 64'(exp_order[k]));
        check("thru_count", 64'(hs_cyc.size() >= 5), 64'd1);
        for (int k = 0; k + 1 < 5 && k + 1 < hs_cyc.size(); k++)
            check("thru_gap", 64'(hs_cyc[k+1] - hs_cyc[k]), 64'd2);

        // Backpressure in RESP, then same-cycle grant to req2.
        res_ready = 1'b0;
        set_req(0, 55'h1234, 39'h10);
        step();
        req_valid = '0;
        step();
        set_req(2, 55'h100, 39'h5);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_valid", 64'(res_valid), 64'd1);
            check("bp_ready", 64'(req_ready), 64'd0);
            check("bp_sum", 64'(res_sum), 64'h1244);
            check("bp_id", 64'(res_id), 64'd0);
            step();
        end
        res_ready = 1'b1;
        #1;
        check("bp_grant2", 64'(req_ready), 64'b0100);
        step();
        req_valid = '0;
        wait_result();
        check("bp_sum2", 64'(res_sum), 64'h105);
        check("bp_id2", 64'(res_id), 64'd2);
        step();

        // Pointer wrap: req3 alone, then req0 and req3 together.
        do_reset();
        res_ready = 1'b1;
        set_req(3, 55'h3, 39'h3);
        #1;
        check("wrap_g3", 64'(req_ready), 64'b1000);
        step();
        req_valid = '0;
        repeat (2) step();
        set_req(0, 55'h9, 39'h1);
        set_req(3, 55'h8, 39'h2);
        #1;
        check("wrap_g0", 64'(req_ready), 64'b0001);
        step();
        req_valid = '0;
        repeat (3) step();

        // Reset while in EXEC.
        set_req(2, 55'h77, 39'h1);
        step();
        req_valid = '0;
        check("mid_busy_pre", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("mid_res_valid", 64'(res_valid), 64'd0);
        check("mid_busy", 64'(busy), 64'd0);
        set_req(1, 55'h40, 39'h2);
        set_req(3, 55'h50, 39'h3);
        #1;
        check("mid_ptr_g1", 64'(req_ready), 64'b0010);
        step();
        req_valid = '0;
        wait_result();
        check("mid_sum", 64'(res_sum), 64'h42);
        check("mid_id", 64'(res_id), 64'd1);
        step();
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
